sar_search_ctrl: RTL

- Successive-approximation search controller: the initiator side of a magnitude-compare interface.
- Drives a trial operand B onto an external magnitude comparator. The comparator reports g/l/e for an unknown target A against that trial.
- Converges MSB-first on the value of A and returns it with a done/found handshake.
- Sits in front of any combinational comparator whose outputs are one-hot g (A>B), l (A<B), e (A==B).

---
 rtl/sar_pkg.sv | 15 +
 rtl/sar_search_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTry,
    StVerify
  } sar_state_e;

  // True when exactly one of the comparator flags is set.
  function automatic logic onehot3(input logic g, input logic l, input logic e);
    return (g & ~l & ~e) | (~g & l & ~e) | (~g & ~l & e);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a trial operand onto an
// external magnitude comparator and converges MSB-first on the target value.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         cmp_g,
  input  logic         cmp_l,
  input  logic         cmp_e,
  output logic [W-1:0] trial,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         err,
  output logic [W-1:0] result
);

  localparam int unsigned IdxW = $clog2(W);
  localparam logic [W-1:0] TrialMsb = {1'b1, {(W-1){1'b0}}};
  localparam logic [IdxW-1:0] IdxMsb = IdxW'(W - 1);

  sar_state_e state_q, state_d;
  logic [W-1:0]    trial_q, trial_d;
  logic [W-1:0]    result_q, result_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] idx_dec;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            found_q, found_d;
  logic            err_q, err_d;
  logic            cmp_ok;

  assign cmp_ok  = onehot3(cmp_g, cmp_l, cmp_e);
  assign idx_dec = idx_q - IdxW'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Next-state, next-trial and completion logic.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    found_d  = found_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped, not queued.
        if (start && !done_q) begin
          trial_d = TrialMsb;
          idx_d   = IdxMsb;
          busy_d  = 1'b1;
          state_d = StTry;
        end
      end

      StTry: begin
        if (!cmp_ok) begin
          result_d = trial_q;
          found_d  = 1'b0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else if (cmp_e) begin
          result_d = trial_q;
          found_d  = 1'b1;
          err_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end else begin
          // Keep the bit on "greater", clear it on "less".
          trial_d[idx_q] = cmp_g;
          if (idx_q != '0) begin
            trial_d[idx_dec] = 1'b1;
            idx_d            = idx_dec;
          end else begin
            state_d = StVerify;
          end
        end
      end

      StVerify: begin
        result_d = trial_q;
        found_d  = cmp_ok & cmp_e;
        err_d    = ~cmp_ok;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule
